// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control unit for the multicycle MIPS datapath. A Moore main-decoder FSM
// steps each instruction through its datapath phases. A combinational ALU
// decoder turns the FSM's aluop and the instruction's funct field into the
// ALU operation code.
//
// Parameters:
//   ENABLE_ADDI : 1 = addi (op 001000) decoded, 0 = treated as illegal opcode
//   ENABLE_J    : 1 = j    (op 000010) decoded, 0 = treated as illegal opcode
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  asynchronous, active-low reset
//   op         in   6  opcode field [31:26] from the instruction register
//   funct      in   6  function field [5:0] from the instruction register
//   zero       in   1  ALU zero flag
//   pcen       out  1  PC register enable (pcwrite | branch & zero)
//   irwrite    out  1  instruction register enable
//   memwrite   out  1  memory write strobe
//   regwrite   out  1  register file write enable
//   iord       out  1  memory address select: 0 = PC, 1 = ALUOut
//   alusrca    out  1  ALU A select: 0 = PC, 1 = register A
//   alusrcb    out  2  ALU B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   regdst     out  1  write-register select: 0 = rt, 1 = rd
//   memtoreg   out  1  write-data select: 0 = ALUOut, 1 = Data
//   pcsrc      out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump
//   alucontrol out  3  ALU operation
//   state_o    out  4  current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter bit ENABLE_ADDI = 1'b1,
   parameter bit ENABLE_J    = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       pcen,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic       iord,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       regdst,
   output logic       memtoreg,
   output logic [1:0] pcsrc,
   output logic [2:0] alucontrol,
   output logic [3:0] state_o
);

   // Opcodes recognised by the main decoder
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes understood by the ALU decoder
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   // ALU operation codes
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Encodings 12..15 are never entered; the next-state default maps them to FETCH.
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_t;

   state_t     state;
   state_t     state_next;

   // Raw Moore decodes, before reset gating and the branch term
   logic       pcwrite;
   logic       branch;
   logic       irwrite_s;
   logic       memwrite_s;
   logic       regwrite_s;
   logic [1:0] aluop;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs, independent of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and Moore output decode
   // ---------------------------------------------------------------------------
   // NOTE: every signal driven here receives a default before the case
   // statement, so no path through the block leaves one unassigned and no
   // latch is inferred.
   always_comb begin
      state_next = FETCH;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      irwrite_s  = 1'b0;
      memwrite_s = 1'b0;
      regwrite_s = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      pcsrc      = 2'b00;
      aluop      = 2'b00;

      case (state)
         FETCH: begin
            // PC + 4 is computed and written while the instruction is latched
            alusrcb    = 2'b01;
            irwrite_s  = 1'b1;
            pcwrite    = 1'b1;
            state_next = DECODE;
         end

         DECODE: begin
            // Branch target PC + (SignImm << 2) is precomputed into ALUOut
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_RTYPE:     state_next = RTYPEEX;
               OP_BEQ:       state_next = BEQEX;
               OP_ADDI:      state_next = ENABLE_ADDI ? ADDIEX : FETCH;
               OP_J:         state_next = ENABLE_J    ? JEX    : FETCH;
               default:      state_next = FETCH;  // illegal opcode: abandon
            endcase
         end

         MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = (op == OP_LW) ? MEMRD : MEMWR;
         end

         MEMRD: begin
            iord       = 1'b1;
            state_next = MEMWB;
         end

         MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
            state_next = FETCH;
         end

         MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            state_next = FETCH;
         end

         RTYPEEX: begin
            alusrca    = 1'b1;
            aluop      = 2'b10;
            state_next = RTYPEWB;
         end

         RTYPEWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
            state_next = FETCH;
         end

         BEQEX: begin
            // Compare A - B; the PC takes ALUOut only if zero is asserted
            alusrca    = 1'b1;
            aluop      = 2'b01;
            pcsrc      = 2'b01;
            branch     = 1'b1;
            state_next = FETCH;
         end

         ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = ADDIWB;
         end

         ADDIWB: begin
            regwrite_s = 1'b1;
            state_next = FETCH;
         end

         JEX: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            state_next = FETCH;
         end

         default: state_next = FETCH;
      endcase
   end

   // ---------------------------------------------------------------------------
   // ALU decoder
   // ---------------------------------------------------------------------------
   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         2'b00: alucontrol = ALU_ADD;
         2'b01: alucontrol = ALU_SUB;
         2'b10: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Write enables
   // ---------------------------------------------------------------------------
   // The register sits at FETCH during reset, and FETCH asserts pcwrite and
   // irwrite. The enables are therefore qualified by reset directly, so the
   // downstream enable-flops are never written while reset is held.
   assign pcen     = reset & (pcwrite | (branch & zero));
   assign irwrite  = reset & irwrite_s;
   assign memwrite = reset & memwrite_s;
   assign regwrite = reset & regwrite_s;

   assign state_o  = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Scoreboard bench for the multicycle MIPS control unit. Two instances are
// driven from the same inputs: dut_a has every instruction enabled, and dut_b
// has addi and j disabled. For each cycle, the stimulus process pushes the
// expected outputs of both instances into two queues. The expected state
// sequences are hand-written per instruction. The monitor pops those entries
// on the falling edge and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ILL   = 6'b111111;

   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_BAD = 6'b001000;

   typedef struct packed {
      logic [3:0] st;
      logic       pcen;
      logic       irwrite;
      logic       memwrite;
      logic       regwrite;
      logic       iord;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       regdst;
      logic       memtoreg;
      logic [1:0] pcsrc;
      logic [2:0] aluctl;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;

   logic       pcen_a, irwrite_a, memwrite_a, regwrite_a, iord_a, alusrca_a;
   logic       regdst_a, memtoreg_a;
   logic [1:0] alusrcb_a, pcsrc_a;
   logic [2:0] alucontrol_a;
   logic [3:0] state_a;

   logic       pcen_b, irwrite_b, memwrite_b, regwrite_b, iord_b, alusrca_b;
   logic       regdst_b, memtoreg_b;
   logic [1:0] alusrcb_b, pcsrc_b;
   logic [2:0] alucontrol_b;
   logic [3:0] state_b;

   exp_t       got_a;
   exp_t       got_b;
   exp_t       qa[$];
   exp_t       qb[$];

   int         n_tests = 0;
   int         n_fail  = 0;
   int         cyc_n   = 0;

   mips_multicycle_ctrl #(.ENABLE_ADDI(1'b1), .ENABLE_J(1'b1)) dut_a (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen_a), .irwrite(irwrite_a), .memwrite(memwrite_a),
      .regwrite(regwrite_a), .iord(iord_a), .alusrca(alusrca_a),
      .alusrcb(alusrcb_a), .regdst(regdst_a), .memtoreg(memtoreg_a),
      .pcsrc(pcsrc_a), .alucontrol(alucontrol_a), .state_o(state_a)
   );

   mips_multicycle_ctrl #(.ENABLE_ADDI(1'b0), .ENABLE_J(1'b0)) dut_b (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .pcen(pcen_b), .irwrite(irwrite_b), .memwrite(memwrite_b),
      .regwrite(regwrite_b), .iord(iord_b), .alusrca(alusrca_b),
      .alusrcb(alusrcb_b), .regdst(regdst_b), .memtoreg(memtoreg_b),
      .pcsrc(pcsrc_b), .alucontrol(alucontrol_b), .state_o(state_b)
   );

   assign got_a = {state_a, pcen_a, irwrite_a, memwrite_a, regwrite_a, iord_a,
                   alusrca_a, alusrcb_a, regdst_a, memtoreg_a, pcsrc_a,
                   alucontrol_a};
   assign got_b = {state_b, pcen_b, irwrite_b, memwrite_b, regwrite_b, iord_b,
                   alusrca_b, alusrcb_b, regdst_b, memtoreg_b, pcsrc_b,
                   alucontrol_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for a given state, taken from the state/output table
   function automatic exp_t model(input logic [3:0] st, input logic [5:0] f,
                                  input logic z, input logic rst_v);
      exp_t       e;
      logic [1:0] aluop;
      logic       pcwrite;
      logic       branch;
      e       = '0;
      aluop   = 2'b00;
      pcwrite = 1'b0;
      branch  = 1'b0;
      e.st    = st;
      case (st)
         4'd0:  begin e.alusrcb = 2'b01; e.irwrite = 1'b1; pcwrite = 1'b1; end
         4'd1:  e.alusrcb = 2'b11;
         4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         4'd3:  e.iord = 1'b1;
         4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; end
         4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; end
         4'd6:  begin e.alusrca = 1'b1; aluop = 2'b10; end
         4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; end
         4'd8:  begin e.alusrca = 1'b1; aluop = 2'b01; e.pcsrc = 2'b01; branch = 1'b1; end
         4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
         4'd10: e.regwrite = 1'b1;
         4'd11: begin e.pcsrc = 2'b10; pcwrite = 1'b1; end
         default: ;
      endcase
      e.pcen = pcwrite | (branch & z);
      case (aluop)
         2'b01: e.aluctl = 3'b110;
         2'b10: begin
            case (f)
               6'b100000: e.aluctl = 3'b010;
               6'b100010: e.aluctl = 3'b110;
               6'b100100: e.aluctl = 3'b000;
               6'b100101: e.aluctl = 3'b001;
               6'b101010: e.aluctl = 3'b111;
               default:   e.aluctl = 3'b010;
            endcase
         end
         default: e.aluctl = 3'b010;
      endcase
      if (!rst_v) begin
         e.pcen     = 1'b0;
         e.irwrite  = 1'b0;
         e.memwrite = 1'b0;
         e.regwrite = 1'b0;
      end
      return e;
   endfunction

   // One clock cycle: apply the inputs just after the edge, then queue the
   // expected state of each DUT for this cycle.
   task automatic cyc(input logic rst_v, input logic [5:0] op_v,
                      input logic [5:0] f_v, input logic z_v,
                      input logic [3:0] sa, input logic [3:0] sb);
      @(posedge clk);
      #1;
      reset = rst_v;
      op    = op_v;
      funct = f_v;
      zero  = z_v;
      qa.push_back(model(sa, f_v, z_v, rst_v));
      qb.push_back(model(sb, f_v, z_v, rst_v));
   endtask

   // Monitor: sample on the falling edge, well away from the active edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (qa.size() > 0) begin
            e = qa.pop_front();
            n_tests++;
            if (got_a !== e) begin
               n_fail++;
               $display("FAIL dut_a cycle %0d: got state=%0d vec=%h, required state=%0d vec=%h",
                        cyc_n, got_a.st, got_a, e.st, e);
            end
         end
         if (qb.size() > 0) begin
            e = qb.pop_front();
            n_tests++;
            if (got_b !== e) begin
               n_fail++;
               $display("FAIL dut_b cycle %0d: got state=%0d vec=%h, required state=%0d vec=%h",
                        cyc_n, got_b.st, got_b, e.st, e);
            end
         end
         cyc_n++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      op    = OP_ILL;
      funct = 6'b000000;
      zero  = 1'b0;

      // Reset held for two cycles: FETCH with all write enables gated
      cyc(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b0, OP_LW, 6'd0, 1'b0, 4'd0, 4'd0);

      // lw: 0,1,2,3,4 (the release cycle is its FETCH)
      cyc(1'b1, OP_LW, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_LW, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_LW, 6'd0, 1'b0, 4'd2, 4'd2);
      cyc(1'b1, OP_LW, 6'd0, 1'b0, 4'd3, 4'd3);
      cyc(1'b1, OP_LW, 6'd0, 1'b0, 4'd4, 4'd4);

      // R-type sub: 0,1,6,7
      cyc(1'b1, OP_RTYPE, FN_SUB, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_RTYPE, FN_SUB, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_RTYPE, FN_SUB, 1'b0, 4'd6, 4'd6);
      cyc(1'b1, OP_RTYPE, FN_SUB, 1'b0, 4'd7, 4'd7);

      // beq taken, then not taken: 0,1,8
      cyc(1'b1, OP_BEQ, 6'd0, 1'b1, 4'd0, 4'd0);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b1, 4'd1, 4'd1);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b1, 4'd8, 4'd8);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_BEQ, 6'd0, 1'b0, 4'd8, 4'd8);

      // Illegal opcode: 0,1 then back to FETCH
      cyc(1'b1, OP_ILL, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_ILL, 6'd0, 1'b0, 4'd1, 4'd1);

      // Remaining ALU decoder codes, including an unknown funct
      cyc(1'b1, OP_RTYPE, FN_AND, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_RTYPE, FN_AND, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_RTYPE, FN_AND, 1'b0, 4'd6, 4'd6);
      cyc(1'b1, OP_RTYPE, FN_OR,  1'b0, 4'd7, 4'd7);
      cyc(1'b1, OP_RTYPE, FN_OR,  1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_RTYPE, FN_OR,  1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_RTYPE, FN_OR,  1'b0, 4'd6, 4'd6);
      cyc(1'b1, OP_RTYPE, FN_SLT, 1'b0, 4'd7, 4'd7);
      cyc(1'b1, OP_RTYPE, FN_SLT, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_RTYPE, FN_SLT, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_RTYPE, FN_SLT, 1'b0, 4'd6, 4'd6);
      cyc(1'b1, OP_RTYPE, FN_BAD, 1'b0, 4'd7, 4'd7);
      cyc(1'b1, OP_RTYPE, FN_BAD, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_RTYPE, FN_BAD, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_RTYPE, FN_BAD, 1'b0, 4'd6, 4'd6);
      cyc(1'b1, OP_RTYPE, FN_BAD, 1'b0, 4'd7, 4'd7);

      // sw with reset dropped just after MEMADR is entered: the state
      // collapses to FETCH before the falling edge, and memwrite stays low
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b0, OP_SW, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b0, OP_SW, 6'd0, 1'b0, 4'd0, 4'd0);
      // Released: full sw 0,1,2,5
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd2, 4'd2);
      cyc(1'b1, OP_SW, 6'd0, 1'b0, 4'd5, 4'd5);

      // addi: 0,1,9,10 on dut_a; illegal on dut_b (0,1,0,1)
      cyc(1'b1, OP_ADDI, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_ADDI, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_ADDI, 6'd0, 1'b0, 4'd9, 4'd0);
      cyc(1'b1, OP_ADDI, 6'd0, 1'b0, 4'd10, 4'd1);
      // Reset realigns the two instances
      cyc(1'b0, OP_J, 6'd0, 1'b0, 4'd0, 4'd0);

      // j: 0,1,11 on dut_a; illegal on dut_b (0,1,0)
      cyc(1'b1, OP_J, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_J, 6'd0, 1'b0, 4'd1, 4'd1);
      cyc(1'b1, OP_J, 6'd0, 1'b0, 4'd11, 4'd0);
      cyc(1'b0, OP_ILL, 6'd0, 1'b0, 4'd0, 4'd0);
      cyc(1'b1, OP_ILL, 6'd0, 1'b0, 4'd0, 4'd0);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) begin
         @(negedge clk);
      end
      #1;
      n_tests++;
      if (qa.size() != 0 || qb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d/%0d entries left, required 0/0", qa.size(), qb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
